// File: rtl/axi4_slave_mem_pkg.sv
// ---------------------------------------------------------------------------
// axi4_pkg
// Shared types for the AXI4 memory responder: burst encodings, response
// codes, the write/read FSM state enums and a couple of small helpers used
// to derive the word-address shift and to classify unsupported bursts.
// ---------------------------------------------------------------------------
package axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // log2 of the bus width in bytes; also the only AxSIZE we accept.
    function automatic int unsigned axi_size_log2(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // Only full-width FIXED and INCR bursts touch memory; everything else
    // is accepted on the bus but answered with SLVERR.
    function automatic logic burst_bad(input logic [1:0] burst,
                                       input logic [2:0] size,
                                       input logic [2:0] full_size);
        return !((burst == BURST_INCR) || (burst == BURST_FIXED)) ||
               (size != full_size);
    endfunction

endpackage

// File: rtl/axi4_slave_mem_if.sv
// ---------------------------------------------------------------------------
// axi4_master_if
// Five-channel AXI4 bundle (AW, W, B, AR, R) without the optional sideband
// signals. The master modport drives requests, the slave modport responds.
// Parameters: ID_W (id width), ADDR_W (byte address width), DATA_W (data width).
// ---------------------------------------------------------------------------
interface axi4_master_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi4_slave_mem_ram.sv
// ---------------------------------------------------------------------------
// axi4_slave_mem_ram
// Word-organised storage with one byte-enabled write port and one registered
// read port. A read and a write to the same word in the same cycle return the
// old contents (read-before-write). Contents are never reset.
// Ports:
//   aclk          clock
//   we/waddr      write enable and word index
//   wdata/wstrb   write data and per-byte enables
//   re/raddr      read enable and word index; rdata holds when re=0
//   rdata         registered read data
// ---------------------------------------------------------------------------
module axi4_slave_mem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge aclk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi4_slave_mem.sv
// ---------------------------------------------------------------------------
// axi4_slave_mem
// AXI4 responder backed by a local RAM. Independent write (AW/W/B) and read
// (AR/R) FSMs, one transaction at a time on each side.
//
//   state  | meaning
//   W_IDLE | awready=1, waiting for a write address
//   W_DATA | wready=1, accepting awlen+1 beats
//   W_RESP | bvalid=1, holding the write response
//   R_IDLE | arready=1, waiting for a read address
//   R_DATA | rvalid=1, streaming arlen+1 beats
//
// Ports:
//   aclk   clock, rising edge
//   arstn  asynchronous active-low reset
//   s_axi  AXI4 slave modport (all five channels)
// ---------------------------------------------------------------------------
module axi4_slave_mem
    import axi4_pkg::*;
#(
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH        = 1024
) (
    input logic          aclk,
    input logic          arstn,
    axi4_master_if.slave s_axi
);

    localparam int unsigned ADDR_LSB  = axi_size_log2(C_AXI_DATA_WIDTH);
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned STRB_W    = C_AXI_DATA_WIDTH / 8;
    localparam logic [2:0]  FULL_SIZE = 3'(ADDR_LSB);

    // Only the word-index bits of the addresses matter; the rest wrap away.
    logic [C_AXI_ADDR_WIDTH-1:0] unused_addr;
    assign unused_addr = s_axi.awaddr ^ s_axi.araddr;

    // Holds both ready outputs low until the first edge after reset release.
    logic live_q, live_d;

    w_state_e                  w_state_q, w_state_d;
    logic [IDX_W-1:0]          w_idx_q, w_idx_d;
    logic [7:0]                w_cnt_q, w_cnt_d;
    logic                      w_incr_q, w_incr_d;
    logic                      w_err_q, w_err_d;
    logic                      w_last_err_q, w_last_err_d;
    logic [C_AXI_ID_WIDTH-1:0] w_id_q, w_id_d;

    r_state_e                  r_state_q, r_state_d;
    logic [IDX_W-1:0]          r_idx_q, r_idx_d;
    logic [7:0]                r_cnt_q, r_cnt_d;
    logic                      r_incr_q, r_incr_d;
    logic                      r_err_q, r_err_d;
    logic [C_AXI_ID_WIDTH-1:0] r_id_q, r_id_d;

    logic aw_ready, w_ready, b_valid;
    logic [1:0] b_resp;
    logic ar_ready, r_valid, r_last;
    logic [1:0] r_resp;
    logic [C_AXI_DATA_WIDTH-1:0] r_data;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    logic                        ram_we;
    logic                        ram_re;
    logic [IDX_W-1:0]            ram_raddr;
    logic [C_AXI_DATA_WIDTH-1:0] ram_rdata;

    assign live_d = 1'b1;

    assign aw_hs = aw_ready && s_axi.awvalid;
    assign w_hs  = w_ready  && s_axi.wvalid;
    assign b_hs  = b_valid  && s_axi.bready;
    assign ar_hs = ar_ready && s_axi.arvalid;
    assign r_hs  = r_valid  && s_axi.rready;

    // ---------------- state registers ----------------
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            live_q       <= 1'b0;
            w_state_q    <= W_IDLE;
            w_idx_q      <= '0;
            w_cnt_q      <= '0;
            w_incr_q     <= 1'b0;
            w_err_q      <= 1'b0;
            w_last_err_q <= 1'b0;
            w_id_q       <= '0;
            r_state_q    <= R_IDLE;
            r_idx_q      <= '0;
            r_cnt_q      <= '0;
            r_incr_q     <= 1'b0;
            r_err_q      <= 1'b0;
            r_id_q       <= '0;
        end else begin
            live_q       <= live_d;
            w_state_q    <= w_state_d;
            w_idx_q      <= w_idx_d;
            w_cnt_q      <= w_cnt_d;
            w_incr_q     <= w_incr_d;
            w_err_q      <= w_err_d;
            w_last_err_q <= w_last_err_d;
            w_id_q       <= w_id_d;
            r_state_q    <= r_state_d;
            r_idx_q      <= r_idx_d;
            r_cnt_q      <= r_cnt_d;
            r_incr_q     <= r_incr_d;
            r_err_q      <= r_err_d;
            r_id_q       <= r_id_d;
        end
    end

    // ---------------- write next-state ----------------
    always_comb begin
        w_state_d    = w_state_q;
        w_idx_d      = w_idx_q;
        w_cnt_d      = w_cnt_q;
        w_incr_d     = w_incr_q;
        w_err_d      = w_err_q;
        w_last_err_d = w_last_err_q;
        w_id_d       = w_id_q;
        ram_we       = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_state_d    = W_DATA;
                    w_idx_d      = s_axi.awaddr[ADDR_LSB +: IDX_W];
                    w_cnt_d      = s_axi.awlen;
                    w_incr_d     = (s_axi.awburst == BURST_INCR);
                    w_err_d      = burst_bad(s_axi.awburst, s_axi.awsize, FULL_SIZE);
                    w_last_err_d = 1'b0;
                    w_id_d       = s_axi.awid;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    ram_we = !w_err_q;
                    // A misplaced wlast is reported but never shortens or
                    // extends the burst; the beat counter decides.
                    if (s_axi.wlast != (w_cnt_q == 8'd0)) begin
                        w_last_err_d = 1'b1;
                    end
                    if (w_cnt_q == 8'd0) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt_q - 8'd1;
                        if (w_incr_q) begin
                            w_idx_d = w_idx_q + 1'b1;
                        end
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ---------------- write outputs ----------------
    always_comb begin
        aw_ready = live_q && (w_state_q == W_IDLE);
        w_ready  = (w_state_q == W_DATA);
        b_valid  = (w_state_q == W_RESP);
        b_resp   = (b_valid && (w_err_q || w_last_err_q)) ? RESP_SLVERR : RESP_OKAY;
    end

    // ---------------- read next-state ----------------
    // The RAM read port is registered, so each beat is fetched one cycle
    // ahead: on the AR handshake for beat 1, on each accepted beat for the
    // next. With no fetch while stalled, the RAM output holds the beat.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_cnt_d   = r_cnt_q;
        r_incr_d  = r_incr_q;
        r_err_d   = r_err_q;
        r_id_d    = r_id_q;
        ram_re    = 1'b0;
        ram_raddr = r_idx_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    r_idx_d   = s_axi.araddr[ADDR_LSB +: IDX_W];
                    r_cnt_d   = s_axi.arlen;
                    r_incr_d  = (s_axi.arburst == BURST_INCR);
                    r_err_d   = burst_bad(s_axi.arburst, s_axi.arsize, FULL_SIZE);
                    r_id_d    = s_axi.arid;
                    ram_re    = 1'b1;
                    ram_raddr = s_axi.araddr[ADDR_LSB +: IDX_W];
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (r_cnt_q == 8'd0) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d = r_cnt_q - 8'd1;
                        if (r_incr_q) begin
                            r_idx_d = r_idx_q + 1'b1;
                        end
                        ram_re    = 1'b1;
                        ram_raddr = r_incr_q ? (r_idx_q + 1'b1) : r_idx_q;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ---------------- read outputs ----------------
    always_comb begin
        ar_ready = live_q && (r_state_q == R_IDLE);
        r_valid  = (r_state_q == R_DATA);
        r_last   = r_valid && (r_cnt_q == 8'd0);
        r_resp   = (r_valid && r_err_q) ? RESP_SLVERR : RESP_OKAY;
        r_data   = (r_valid && !r_err_q) ? ram_rdata : '0;
    end

    axi4_slave_mem_ram #(
        .DATA_W (C_AXI_DATA_WIDTH),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W),
        .STRB_W (STRB_W)
    ) u_ram (
        .aclk  (aclk),
        .we    (ram_we),
        .waddr (w_idx_q),
        .wdata (s_axi.wdata),
        .wstrb (s_axi.wstrb),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign s_axi.awready = aw_ready;
    assign s_axi.wready  = w_ready;
    assign s_axi.bvalid  = b_valid;
    assign s_axi.bresp   = b_resp;
    assign s_axi.bid     = w_id_q;
    assign s_axi.arready = ar_ready;
    assign s_axi.rvalid  = r_valid;
    assign s_axi.rlast   = r_last;
    assign s_axi.rresp   = r_resp;
    assign s_axi.rdata   = r_data;
    assign s_axi.rid     = r_id_q;

endmodule

// File: tb/tb_axi4_slave_mem.sv
module tb_axi4_slave_mem;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam logic [1:0] OKAY  = 2'b00;
    localparam logic [1:0] SLV   = 2'b10;

    logic aclk;
    logic arstn;

    axi4_master_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) axi ();

    axi4_slave_mem #(
        .C_AXI_ID_WIDTH   (4),
        .C_AXI_ADDR_WIDTH (32),
        .C_AXI_DATA_WIDTH (32),
        .MEM_DEPTH        (1024)
    ) dut (
        .aclk  (aclk),
        .arstn (arstn),
        .s_axi (axi)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] wbuf [16];
    logic [31:0] rexp [16];

    typedef struct {
        logic [31:0] wr_addr;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_bresp;
        logic [31:0] rd_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: no handshake within bound, got ready=0, expected ready=1", name);
    endtask

    task automatic aw_xfer(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        @(negedge aclk);
        axi.awid = id; axi.awaddr = addr; axi.awlen = len;
        axi.awburst = burst; axi.awsize = size; axi.awvalid = 1'b1;
        for (int i = 0; i < 64 && !axi.awready; i++) @(negedge aclk);
        if (!axi.awready) timed_out("aw_handshake");
        @(posedge aclk); #1;
        axi.awvalid = 1'b0;
    endtask

    task automatic ar_xfer(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        @(negedge aclk);
        axi.arid = id; axi.araddr = addr; axi.arlen = len;
        axi.arburst = burst; axi.arsize = size; axi.arvalid = 1'b1;
        for (int i = 0; i < 64 && !axi.arready; i++) @(negedge aclk);
        if (!axi.arready) timed_out("ar_handshake");
        @(posedge aclk); #1;
        axi.arvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        @(negedge aclk);
        axi.wdata = data; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
        for (int i = 0; i < 64 && !axi.wready; i++) @(negedge aclk);
        if (!axi.wready) timed_out("w_handshake");
        @(posedge aclk); #1;
        axi.wvalid = 1'b0;
    endtask

    task automatic b_get(output logic [1:0] resp, output logic [3:0] id);
        @(negedge aclk);
        axi.bready = 1'b1;
        for (int i = 0; i < 64 && !axi.bvalid; i++) @(negedge aclk);
        if (!axi.bvalid) timed_out("b_handshake");
        resp = axi.bresp;
        id   = axi.bid;
        @(posedge aclk); #1;
        axi.bready = 1'b0;
    endtask

    task automatic r_get(output logic [31:0] data, output logic [1:0] resp,
                         output logic last, output logic [3:0] id);
        @(negedge aclk);
        axi.rready = 1'b1;
        for (int i = 0; i < 64 && !axi.rvalid; i++) @(negedge aclk);
        if (!axi.rvalid) timed_out("r_handshake");
        data = axi.rdata; resp = axi.rresp; last = axi.rlast; id = axi.rid;
        @(posedge aclk); #1;
        axi.rready = 1'b0;
    endtask

    // Writes wbuf[0..len]; drop_last clears wlast on every beat.
    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [2:0] size, input logic [3:0] strb,
                               input logic drop_last, input logic [1:0] exp_resp, input string tag);
        logic [1:0] resp;
        logic [3:0] bid;
        aw_xfer(id, addr, len, burst, size);
        for (int i = 0; i <= int'(len); i++) begin
            w_beat(wbuf[i], strb, drop_last ? 1'b0 : (i == int'(len)));
        end
        b_get(resp, bid);
        check({tag, " bresp"}, resp, exp_resp);
        check({tag, " bid"}, bid, id);
    endtask

    // Reads len+1 beats and compares against rexp[].
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [1:0] exp_resp, input string tag);
        logic [31:0] d;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  rid;
        ar_xfer(id, addr, len, burst, 3'd2);
        check({tag, " rvalid one cycle after AR"}, axi.rvalid, 1'b1);
        for (int i = 0; i <= int'(len); i++) begin
            r_get(d, resp, last, rid);
            check($sformatf("%s rdata[%0d]", tag, i), d, rexp[i]);
            check($sformatf("%s rresp[%0d]", tag, i), resp, exp_resp);
            check($sformatf("%s rlast[%0d]", tag, i), last, (i == int'(len)));
            check($sformatf("%s rid[%0d]", tag, i), rid, id);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [11:0] rr_pat;
        logic [31:0] held_d;
        logic        held_l;
        logic        held_v;
        int          beat;

        vecs[0] = '{32'h000,  INCR, 3'd2, 32'hDEADBEEF, 4'hF, OKAY, 32'h000, 32'hDEADBEEF};
        vecs[1] = '{32'h004,  INCR, 3'd2, 32'h01234567, 4'hF, OKAY, 32'h004, 32'h01234567};
        vecs[2] = '{32'h004,  INCR, 3'd2, 32'hFFFFFFFF, 4'h8, OKAY, 32'h004, 32'hFF234567};
        vecs[3] = '{32'h004,  FIXED,3'd2, 32'h00000000, 4'h1, OKAY, 32'h004, 32'hFF234500};
        vecs[4] = '{32'hFFC,  INCR, 3'd2, 32'hCAFEF00D, 4'hF, OKAY, 32'hFFC, 32'hCAFEF00D};
        vecs[5] = '{32'h1000, INCR, 3'd2, 32'h5A5A5A5A, 4'hF, OKAY, 32'h000, 32'h5A5A5A5A};
        vecs[6] = '{32'h000,  INCR, 3'd1, 32'h12345678, 4'hF, SLV,  32'h000, 32'h5A5A5A5A};
        vecs[7] = '{32'h200,  INCR, 3'd2, 32'hAABBCCDD, 4'hF, OKAY, 32'h200, 32'hAABBCCDD};
        vecs[8] = '{32'h200,  INCR, 3'd2, 32'h11223344, 4'h5, OKAY, 32'h200, 32'hAA22CC44};
        vecs[9] = '{32'h006,  INCR, 3'd2, 32'h0BADCAFE, 4'hF, OKAY, 32'h004, 32'h0BADCAFE};

        arstn = 1'b0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;

        // Reset state
        repeat (3) @(negedge aclk);
        check("reset outputs", {axi.awready, axi.wready, axi.bvalid, axi.bresp, axi.bid,
                                axi.arready, axi.rvalid, axi.rdata, axi.rresp, axi.rlast, axi.rid}, 64'h0);
        arstn = 1'b1;
        #1;
        check("awready before first edge", axi.awready, 1'b0);
        @(posedge aclk); #1;
        check("awready after first edge", axi.awready, 1'b1);
        check("arready after first edge", axi.arready, 1'b1);

        // Single-beat vector table
        for (int v = 0; v < 10; v++) begin
            wbuf[0] = vecs[v].wdata;
            write_burst(4'(v), vecs[v].wr_addr, 8'd0, vecs[v].burst, vecs[v].size, vecs[v].wstrb,
                        1'b0, vecs[v].exp_bresp, $sformatf("vec%0d", v));
            rexp[0] = vecs[v].exp_rdata;
            read_burst(4'(v + 1), vecs[v].rd_addr, 8'd0, INCR, OKAY, $sformatf("vec%0d", v));
        end

        // INCR 4-beat write and read-back at 0x100
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        write_burst(4'h2, 32'h100, 8'd3, INCR, 3'd2, 4'hF, 1'b0, OKAY, "incr4");
        rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
        read_burst(4'h3, 32'h100, 8'd3, INCR, OKAY, "incr4");

        // rready throttling: each stalled beat must hold, no loss or repeat
        wbuf[0] = 32'hC0; wbuf[1] = 32'hC1; wbuf[2] = 32'hC2; wbuf[3] = 32'hC3;
        write_burst(4'h4, 32'h300, 8'd3, INCR, 3'd2, 4'hF, 1'b0, OKAY, "stall");
        ar_xfer(4'h5, 32'h300, 8'd3, INCR, 3'd2);
        rr_pat = 12'b1111_0110_1001;
        beat = 0;
        held_v = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        for (int c = 0; c < 12 && beat < 4; c++) begin
            @(negedge aclk);
            if (held_v) begin
                check("stall rvalid held", axi.rvalid, 1'b1);
                check("stall rdata held", axi.rdata, held_d);
                check("stall rlast held", axi.rlast, held_l);
            end
            axi.rready = rr_pat[c];
            if (axi.rvalid && axi.rready) begin
                check($sformatf("stall rdata[%0d]", beat), axi.rdata, 32'hC0 + 32'(beat));
                check($sformatf("stall rlast[%0d]", beat), axi.rlast, (beat == 3));
                beat++;
                held_v = 1'b0;
            end else if (axi.rvalid) begin
                held_v = 1'b1;
                held_d = axi.rdata;
                held_l = axi.rlast;
            end else begin
                held_v = 1'b0;
            end
        end
        @(negedge aclk);
        axi.rready = 1'b0;
        check("stall beats received", beat, 4);
        check("stall no extra beat", axi.rvalid, 1'b0);

        // WRAP write is refused, missing wlast still writes
        wbuf[0] = 32'h0BADF00D;
        write_burst(4'h6, 32'h400, 8'd0, INCR, 3'd2, 4'hF, 1'b0, OKAY, "wrap pre");
        wbuf[0] = 32'hFFFFFFFF; wbuf[1] = 32'hEEEEEEEE;
        write_burst(4'h7, 32'h400, 8'd1, WRAP, 3'd2, 4'hF, 1'b0, SLV, "wrap");
        rexp[0] = 32'h0BADF00D;
        read_burst(4'h8, 32'h400, 8'd0, INCR, OKAY, "wrap unchanged");
        wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222;
        write_burst(4'h9, 32'h408, 8'd1, INCR, 3'd2, 4'hF, 1'b1, SLV, "nolast");
        rexp[0] = 32'h11111111; rexp[1] = 32'h22222222;
        read_burst(4'hA, 32'h408, 8'd1, INCR, OKAY, "nolast readback");
        rexp[0] = 32'h0; rexp[1] = 32'h0;
        read_burst(4'hB, 32'h400, 8'd1, WRAP, SLV, "wrap read");

        // Reset in the middle of an 8-beat read
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h50 + 32'(i);
        write_burst(4'hC, 32'h500, 8'd7, INCR, 3'd2, 4'hF, 1'b0, OKAY, "rst pre");
        ar_xfer(4'hD, 32'h500, 8'd7, INCR, 3'd2);
        begin
            logic [31:0] d;
            logic [1:0]  resp;
            logic        last;
            logic [3:0]  rid;
            r_get(d, resp, last, rid);
            check("rst beat1 rdata", d, 32'h50);
        end
        @(negedge aclk);
        check("rst beat2 presented", axi.rdata, 32'h51);
        arstn = 1'b0;
        #1;
        check("rst rvalid drops at once", axi.rvalid, 1'b0);
        check("rst arready low", axi.arready, 1'b0);
        check("rst awready low", axi.awready, 1'b0);
        check("rst rdata/rlast/rid", {axi.rdata, axi.rlast, axi.rid}, 64'h0);
        @(negedge aclk);
        arstn = 1'b1;
        #1;
        check("rst arready before edge", axi.arready, 1'b0);
        @(posedge aclk); #1;
        check("rst arready after edge", axi.arready, 1'b1);
        check("rst awready after edge", axi.awready, 1'b1);
        check("rst rvalid still low", axi.rvalid, 1'b0);
        rexp[0] = 32'h50; rexp[1] = 32'h51;
        read_burst(4'hE, 32'h500, 8'd1, INCR, OKAY, "post rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
